// File: rtl/dial_pkg.sv
// dial_pkg: shared definitions for the dial-rotation engine
// (FSM states, result-select codes, direction bit values).
package dial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIV   = 2'd1,
    ST_APPLY = 2'd2
  } state_e;

  localparam logic [1:0] SEL_POS    = 2'd0;
  localparam logic [1:0] SEL_HITS   = 2'd1;
  localparam logic [1:0] SEL_PASSES = 2'd2;
  localparam logic [1:0] SEL_ROTS   = 2'd3;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/dial_divider.sv
// dial_divider: MAG_W-cycle restoring divider of a magnitude by the
// constant DIAL_SIZE. Loads on start, performs one quotient bit per
// cycle, and raises done during the cycle of the final step.
// The quotient register exists only when DIAL_PASS_COUNT_EN is defined.
module dial_divider #(
  parameter int MAG_W     = 16,
  parameter int DIAL_SIZE = 100,
  parameter int REM_W     = $clog2(DIAL_SIZE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [MAG_W-1:0]   dividend,
`ifdef DIAL_PASS_COUNT_EN
  output logic [MAG_W-1:0]   quotient,
`endif
  output logic [REM_W-1:0]   remainder,
  output logic               done
);

  localparam int CW = $clog2(MAG_W + 1);
  localparam logic [REM_W:0]  DIV_K = (REM_W+1)'(DIAL_SIZE);
  localparam logic [CW-1:0]   LAST  = CW'(MAG_W - 1);

  logic              busy;
  logic [CW-1:0]     cnt;
  logic [MAG_W-1:0]  dvd;
  logic [REM_W-1:0]  rem_q;
  logic [REM_W:0]    trial;
  logic              ge;
  logic [REM_W-1:0]  rem_step;

  assign trial    = {rem_q, dvd[MAG_W-1]};
  assign ge       = (trial >= DIV_K);
  assign rem_step = ge ? REM_W'(trial - DIV_K) : trial[REM_W-1:0];
  assign done     = busy && (cnt == LAST);
  assign remainder = rem_q;

  // Step sequencing: busy/counter; abort drops an in-flight divide
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (abort) begin
      busy <= 1'b0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      cnt <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

  // Datapath: shift dividend out MSB-first, restore-subtract into remainder
  always_ff @(posedge clk) begin
    if (start) begin
      dvd   <= dividend;
      rem_q <= '0;
    end else if (busy) begin
      dvd   <= dvd << 1;
      rem_q <= rem_step;
    end
  end

`ifdef DIAL_PASS_COUNT_EN
  // Quotient accumulation: one full-turn bit per step
  always_ff @(posedge clk) begin
    if (start)     quotient <= '0;
    else if (busy) quotient <= (quotient << 1) | MAG_W'(ge);
  end
`endif

endmodule

// File: rtl/dial_coprocessor.sv
// dial_coprocessor: dial-rotation engine. Accepts signed rotation
// commands, divides the magnitude by DIAL_SIZE, applies the remainder
// modulo DIAL_SIZE and updates landed-on-zero / passed-zero counters.
// Optional feature macro: DIAL_PASS_COUNT_EN (zero_passes counter).
module dial_coprocessor
  import dial_pkg::*;
#(
  parameter int MAG_W     = 16,
  parameter int DIAL_SIZE = 100,
  parameter int START_POS = 50,
  parameter int COUNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [MAG_W:0]     din,
  input  logic               din_valid,
  output logic               din_ready,
  input  logic               clear,
  input  logic [1:0]         sel,
  output logic [COUNT_W-1:0] dout,
  output logic               dout_valid
);

  localparam int PW = $clog2(DIAL_SIZE);
  localparam logic [PW:0]   DIAL_K  = (PW+1)'(DIAL_SIZE);
  localparam logic [PW-1:0] START_K = PW'(START_POS);

  state_e              state_q, state_d;
  logic                start, apply;
  logic                dir_q;
  logic                div_done;
  logic [PW-1:0]       rem;
  logic [PW:0]         sum;
  logic [PW-1:0]       pos_q, pos_d, pos_new;
  logic [COUNT_W-1:0]  hits_q, hits_d, rots_q, rots_d, dout_d;
`ifdef DIAL_PASS_COUNT_EN
  logic [MAG_W-1:0]    quo;
  logic                cross;
  logic [COUNT_W-1:0]  passes_q, passes_d;
`endif

  dial_divider #(
    .MAG_W     (MAG_W),
    .DIAL_SIZE (DIAL_SIZE),
    .REM_W     (PW)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (clear),
    .dividend  (din[MAG_W-1:0]),
`ifdef DIAL_PASS_COUNT_EN
    .quotient  (quo),
`endif
    .remainder (rem),
    .done      (div_done)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state and control strobes; clear overrides everything
  always_comb begin
    state_d   = state_q;
    din_ready = 1'b0;
    start     = 1'b0;
    apply     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        din_ready = 1'b1;
        if (din_valid && !clear) begin
          start   = 1'b1;
          state_d = ST_DIV;
        end
      end
      ST_DIV:   if (div_done) state_d = ST_APPLY;
      ST_APPLY: begin
        apply   = 1'b1;
        state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
    if (clear) begin
      state_d = ST_IDLE;
      apply   = 1'b0;
    end
  end

  // Direction is held for the whole command
  always_ff @(posedge clk) begin
    if (start) dir_q <= din[MAG_W];
  end

  assign sum = {1'b0, pos_q} + {1'b0, rem};

  // New position from the sub-turn remainder
  always_comb begin
    pos_new = pos_q;
    if (dir_q == DIR_RIGHT) begin
      if (sum >= DIAL_K) pos_new = PW'(sum - DIAL_K);
      else               pos_new = sum[PW-1:0];
    end else if (rem == '0) begin
      pos_new = pos_q;
    end else if (rem < pos_q) begin
      pos_new = pos_q - rem;
    end else if (rem == pos_q) begin
      pos_new = '0;
    end else begin
      pos_new = PW'({1'b0, pos_q} + DIAL_K - {1'b0, rem});
    end
  end

`ifdef DIAL_PASS_COUNT_EN
  // Partial-turn crossing: a left move only crosses if it did not start on zero
  always_comb begin
    if (dir_q == DIR_RIGHT) cross = (sum >= DIAL_K);
    else                    cross = (pos_q != '0) && (rem >= pos_q);
  end
`endif

  // Next values of position and counters (clear wins over apply)
  always_comb begin
    pos_d  = pos_q;
    hits_d = hits_q;
    rots_d = rots_q;
`ifdef DIAL_PASS_COUNT_EN
    passes_d = passes_q;
`endif
    if (clear) begin
      pos_d  = START_K;
      hits_d = '0;
      rots_d = '0;
`ifdef DIAL_PASS_COUNT_EN
      passes_d = '0;
`endif
    end else if (apply) begin
      pos_d  = pos_new;
      hits_d = hits_q + COUNT_W'(pos_new == '0);
      rots_d = rots_q + COUNT_W'(1);
`ifdef DIAL_PASS_COUNT_EN
      passes_d = passes_q + COUNT_W'(quo) + COUNT_W'(cross);
`endif
    end
  end

  // Result mux over next values so dout reflects the update with dout_valid
  always_comb begin
    dout_d = '0;
    case (sel)
      SEL_POS:    dout_d = COUNT_W'(pos_d);
      SEL_HITS:   dout_d = hits_d;
`ifdef DIAL_PASS_COUNT_EN
      SEL_PASSES: dout_d = passes_d;
`else
      SEL_PASSES: dout_d = '0;
`endif
      SEL_ROTS:   dout_d = rots_d;
      default:    dout_d = '0;
    endcase
  end

  // Architectural state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_q      <= START_K;
      hits_q     <= '0;
      rots_q     <= '0;
`ifdef DIAL_PASS_COUNT_EN
      passes_q   <= '0;
`endif
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      pos_q      <= pos_d;
      hits_q     <= hits_d;
      rots_q     <= rots_d;
`ifdef DIAL_PASS_COUNT_EN
      passes_q   <= passes_d;
`endif
      dout       <= dout_d;
      dout_valid <= apply;
    end
  end

endmodule

// File: tb/tb_dial_coprocessor.sv
// tb_dial_coprocessor: scoreboard bench for dial_coprocessor with a
// click-counting reference model of the dial.
module tb_dial_coprocessor;

  localparam int MAG_W     = 16;
  localparam int DIAL_SIZE = 100;
  localparam int START_POS = 50;
  localparam int COUNT_W   = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [MAG_W:0]     din = '0;
  logic               din_valid = 1'b0;
  logic               din_ready;
  logic               clear = 1'b0;
  logic [1:0]         sel = 2'd0;
  logic [COUNT_W-1:0] dout;
  logic               dout_valid;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dial_coprocessor #(
    .MAG_W     (MAG_W),
    .DIAL_SIZE (DIAL_SIZE),
    .START_POS (START_POS),
    .COUNT_W   (COUNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .clear      (clear),
    .sel        (sel),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  // Reference model: dial position and counters
  int                 m_pos;
  logic [COUNT_W-1:0] m_hits, m_passes, m_rots;
  logic [COUNT_W-1:0] exp_q[$];

  function automatic logic [COUNT_W-1:0] exp_passes(input logic [COUNT_W-1:0] v);
`ifdef DIAL_PASS_COUNT_EN
    return v;
`else
    return '0;
`endif
  endfunction

  function automatic void model_reset();
    m_pos    = START_POS;
    m_hits   = '0;
    m_passes = '0;
    m_rots   = '0;
  endfunction

  // Count every click that lands on zero while turning mag clicks
  function automatic void model_move(input bit left, input int mag);
    int crossings;
    if (!left) begin
      crossings = (m_pos + mag) / DIAL_SIZE;
      m_pos     = (m_pos + mag) % DIAL_SIZE;
    end else begin
      if (m_pos == 0)       crossings = mag / DIAL_SIZE;
      else if (mag >= m_pos) crossings = 1 + (mag - m_pos) / DIAL_SIZE;
      else                   crossings = 0;
      m_pos = ((m_pos - mag) % DIAL_SIZE + DIAL_SIZE) % DIAL_SIZE;
    end
    m_passes = m_passes + COUNT_W'(crossings);
    m_hits   = m_hits + COUNT_W'(m_pos == 0);
    m_rots   = m_rots + COUNT_W'(1);
  endfunction

  function automatic logic [COUNT_W-1:0] model_field(input logic [1:0] s);
    case (s)
      2'd0:    return COUNT_W'(m_pos);
      2'd1:    return m_hits;
      2'd2:    return exp_passes(m_passes);
      default: return m_rots;
    endcase
  endfunction

  task automatic check(input string name, input logic [COUNT_W-1:0] act,
                       input logic [COUNT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Monitor: every dout_valid pulse must match the oldest expectation
  always @(negedge clk) begin
    if (dout_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_dout_valid: got pulse with dout=%0d, required none", dout);
      end else begin
        check("scoreboard_dout", dout, exp_q.pop_front());
      end
    end
  end

  // Issue one command from idle and wait for its result pulse
  task automatic send(input bit left, input int mag, input logic [1:0] s,
                      input bit hold_busy);
    int lat;
    bit got;
    sel       = s;
    din       = {left, MAG_W'(mag)};
    din_valid = 1'b1;
    @(posedge clk);
    model_move(left, mag);
    exp_q.push_back(model_field(s));
    #1;
    if (!hold_busy) din_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (dout_valid) begin
        got = 1'b1;
        break;
      end
      if (hold_busy) din = (MAG_W+1)'($urandom);
    end
    din_valid = 1'b0;
    if (got) begin
      check("latency", COUNT_W'(lat), COUNT_W'(MAG_W + 1));
    end else begin
      checks++;
      failures++;
      $display("FAIL latency_timeout: no dout_valid after %0d edges, required %0d", lat, MAG_W + 1);
    end
  endtask

  task automatic read_field(input string name, input logic [1:0] s,
                            input logic [COUNT_W-1:0] exp);
    sel = s;
    @(posedge clk);
    #1;
    check(name, dout, exp);
  endtask

  task automatic read_all_model();
    read_field("model_pos",    2'd0, model_field(2'd0));
    read_field("model_hits",   2'd1, model_field(2'd1));
    read_field("model_passes", 2'd2, model_field(2'd2));
    read_field("model_rots",   2'd3, model_field(2'd3));
  endtask

  typedef struct { bit left; int mag; } cmd_t;
  cmd_t seq[10];

  initial begin
    model_reset();
    #22;
    check("reset_din_ready",  COUNT_W'(din_ready), COUNT_W'(1));
    check("reset_dout_valid", COUNT_W'(dout_valid), COUNT_W'(0));
    check("reset_dout",       dout, '0);
    @(negedge clk);
    rst = 1'b1;

    // First command straight after reset
    send(1'b1, 68, 2'd0, 1'b0);
    read_field("l68_pos",    2'd0, COUNT_W'(82));
    read_field("l68_passes", 2'd2, exp_passes(COUNT_W'(1)));
    read_field("l68_hits",   2'd1, COUNT_W'(0));

    // Reference sequence continuing from L68
    seq = '{'{1,68}, '{1,30}, '{0,48}, '{1,5}, '{0,60},
            '{1,55}, '{1,1}, '{1,99}, '{0,14}, '{1,82}};
    for (int i = 1; i < 10; i++) send(seq[i].left, seq[i].mag, 2'(i % 4), 1'b0);
    read_field("seq_pos",    2'd0, COUNT_W'(32));
    read_field("seq_hits",   2'd1, COUNT_W'(3));
    read_field("seq_passes", 2'd2, exp_passes(COUNT_W'(6)));
    read_field("seq_rots",   2'd3, COUNT_W'(10));

    // Landing on zero, full turns, then leaving zero
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_reset();
    send(1'b0, 50, 2'd1, 1'b0);
    send(1'b0, 1000, 2'd2, 1'b0);
    read_field("r1000_pos",    2'd0, COUNT_W'(0));
    read_field("r1000_hits",   2'd1, COUNT_W'(2));
    read_field("r1000_passes", 2'd2, exp_passes(COUNT_W'(11)));
    send(1'b1, 5, 2'd0, 1'b0);
    read_field("leave0_pos",    2'd0, COUNT_W'(95));
    read_field("leave0_passes", 2'd2, exp_passes(COUNT_W'(11)));

    // din_valid held with changing din while busy
    send(1'b0, 7, 2'd0, 1'b1);
    send(1'b1, 333, 2'd2, 1'b1);
    repeat (25) @(posedge clk);
    #1;
    read_all_model();

    // Asynchronous reset in the middle of a divide
    sel       = 2'd0;
    din       = {1'b0, MAG_W'(250)};
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_din_ready",  COUNT_W'(din_ready), COUNT_W'(1));
    check("midrst_dout_valid", COUNT_W'(dout_valid), COUNT_W'(0));
    check("midrst_dout",       dout, '0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (25) @(posedge clk);
    #1;
    read_field("midrst_pos",  2'd0, COUNT_W'(50));
    read_field("midrst_hits", 2'd1, COUNT_W'(0));
    read_field("midrst_rots", 2'd3, COUNT_W'(0));
    send(1'b0, 50, 2'd0, 1'b0);
    read_field("postrst_pos",  2'd0, COUNT_W'(0));
    read_field("postrst_hits", 2'd1, COUNT_W'(1));

    // clear coincident with valid&ready: command dropped
    sel       = 2'd0;
    din       = {1'b1, MAG_W'(10)};
    din_valid = 1'b1;
    clear     = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    clear     = 1'b0;
    model_reset();
    repeat (25) @(posedge clk);
    #1;
    read_field("clr_pos",  2'd0, COUNT_W'(50));
    read_field("clr_rots", 2'd3, COUNT_W'(0));

    // clear in the middle of a divide: command dropped
    din       = {1'b0, MAG_W'(123)};
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_reset();
    repeat (25) @(posedge clk);
    #1;
    read_all_model();

    // Randomized commands with occasional clears
    for (int i = 0; i < 50; i++) begin
      int mag;
      bit left;
      left = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       mag = $urandom_range(0, 199);
        1:       mag = 100 * $urandom_range(0, 600) + $urandom_range(0, 2) - 1;
        2:       mag = $urandom_range(0, 65535);
        default: begin
          case ($urandom_range(0, 3))
            0:       mag = 0;
            1:       mag = 65535;
            2:       mag = DIAL_SIZE - 1;
            default: mag = DIAL_SIZE;
          endcase
        end
      endcase
      if (mag < 0) mag = 0;
      if (mag > 65535) mag = 65535;
      if ($urandom_range(0, 9) == 0) begin
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        model_reset();
      end
      send(left, mag, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0));
    end
    read_all_model();

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", COUNT_W'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
